// File: rtl/alt_cal_mc_sv.sv
// alt_cal_mc_sv: multi-channel transceiver offset-calibration sequencer.
// For each channel in turn it reads the PMA cal register over DPRIO, samples
// the testbus comparator, nudges the 4-bit tap toward balance and writes it back.
// SIM_MODEL_MODE="TRUE" replaces DPRIO traffic with a pure busy-timer model.
// Optional macro ALT_CAL_SV_TIMEOUT_EN adds a dprio_busy watchdog driving error.
module alt_cal_mc_sv #(
  parameter int          NUMBER_OF_CHANNELS    = 4,
  parameter int          CHANNEL_ADDRESS_WIDTH = 2,
  parameter string       SIM_MODEL_MODE        = "FALSE",
  parameter logic [7:0]  SAMPLE_LENGTH         = 8'd100,
  parameter logic [15:0] PMA_BASE_ADDR         = 16'h0000,
  parameter logic [15:0] CHANNEL_STRIDE        = 16'h0040,
  parameter logic [15:0] TIMEOUT_CYCLES        = 16'd1023
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             start,
  output logic                             busy,
  output logic                             done,
  output logic                             error,
  output logic [CHANNEL_ADDRESS_WIDTH-1:0] cal_channel,
  output logic [15:0]                      dprio_addr,
  output logic                             dprio_rden,
  output logic                             dprio_wren,
  output logic [15:0]                      dprio_dataout,
  input  logic [15:0]                      dprio_datain,
  input  logic                             dprio_busy,
  output logic [8:0]                       quad_addr,
  input  logic [11:0]                      remap_addr,
  input  logic [7:0]                       testbuses
);

  localparam int CAW = CHANNEL_ADDRESS_WIDTH;
  localparam bit SIM = (SIM_MODEL_MODE == "TRUE");
  localparam logic [CAW-1:0] LAST_CH     = CAW'(NUMBER_OF_CHANNELS - 1);
  localparam logic [7:0]     SAMPLE_LAST = SAMPLE_LENGTH - 8'd1;
  localparam logic [8:0]     HALF        = 9'(SAMPLE_LENGTH >> 1);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, SAMPLE, WR_REQ, WR_WAIT, NEXT, DONE} state_t;

  // The timer model has no register to read, so a run begins directly in SAMPLE.
  localparam state_t FIRST_ST = SIM ? SAMPLE : RD_REQ;

  state_t          state, state_n;
  logic [CAW-1:0]  ch;
  logic            pending;
  logic            auto_run;
  logic [7:0]      cnt;
  logic [8:0]      ones;
  logic [15:0]     rdata;
  logic [3:0]      tap;
  logic            launch;
  logic            last_ch;
  logic            sample_end;
  logic            chan_act;
  logic            wait_timeout;
  logic [15:0]     addr_calc;

  // Saturating one-step tap nudge: majority of ones raises the tap, otherwise lowers it.
  function automatic logic [3:0] nudge_tap(input logic [3:0] t, input logic [8:0] n);
    if (n > HALF) return (t == 4'hF) ? 4'hF : t + 4'd1;
    else          return (t == 4'h0) ? 4'h0 : t - 4'd1;
  endfunction

  assign last_ch    = (ch == LAST_CH);
  assign sample_end = (cnt == SAMPLE_LAST);
  assign addr_calc  = PMA_BASE_ADDR + 16'(ch) * CHANNEL_STRIDE + {4'b0000, remap_addr};

`ifdef ALT_CAL_SV_TIMEOUT_EN
  logic [15:0] wd_cnt;
  logic        error_q;
  logic        unused_inputs;

  assign error         = error_q;
  assign unused_inputs = ^testbuses[7:1];
  assign wait_timeout  = ((state == RD_WAIT) || (state == WR_WAIT)) && dprio_busy &&
                         (wd_cnt == TIMEOUT_CYCLES - 16'd1);

  // Watchdog: restarts on every request strobe, counts busy cycles in the wait states.
  always_ff @(posedge clock) begin
    if (reset) begin
      wd_cnt  <= '0;
      error_q <= 1'b0;
    end else begin
      if ((state == RD_REQ) || (state == WR_REQ))
        wd_cnt <= '0;
      else if (((state == RD_WAIT) || (state == WR_WAIT)) && dprio_busy)
        wd_cnt <= wd_cnt + 16'd1;
      if (launch)
        error_q <= 1'b0;
      else if (wait_timeout)
        error_q <= 1'b1;
    end
  end
`else
  logic unused_inputs;

  assign error         = 1'b0;
  assign wait_timeout  = 1'b0;
  assign unused_inputs = ^{testbuses[7:1], TIMEOUT_CYCLES};
`endif

  // State register plus run bookkeeping (channel, pending request, power-up run).
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      ch       <= '0;
      pending  <= 1'b0;
      auto_run <= 1'b1;
      cnt      <= '0;
    end else begin
      state <= state_n;
      if (launch) auto_run <= 1'b0;
      if (launch)
        pending <= 1'b0;
      else if (start && (state != IDLE))
        pending <= 1'b1;
      if (state == DONE)
        ch <= '0;
      else if (state == NEXT)
        ch <= last_ch ? '0 : ch + CAW'(1);
      cnt <= (state == SAMPLE) ? cnt + 8'd1 : 8'd0;
    end
  end

  // Datapath: captured register value, comparator tally and the new tap.
  always_ff @(posedge clock) begin
    if ((state == RD_WAIT) && !dprio_busy)
      rdata <= dprio_datain;
    ones <= (state == SAMPLE) ? ones + 9'(testbuses[0]) : 9'd0;
    if ((state == SAMPLE) && sample_end)
      tap <= nudge_tap(rdata[3:0], ones + 9'(testbuses[0]));
  end

  // Next-state decode and Moore outputs.
  always_comb begin
    state_n       = state;
    launch        = 1'b0;
    chan_act      = (state == RD_REQ) || (state == RD_WAIT) || (state == SAMPLE) ||
                    (state == WR_REQ) || (state == WR_WAIT) || (state == NEXT);
    busy          = (state != IDLE);
    done          = (state == DONE);
    dprio_rden    = (state == RD_REQ);
    dprio_wren    = (state == WR_REQ);
    dprio_dataout = (state == WR_REQ) ? {rdata[15:4], tap} : 16'h0000;
    dprio_addr    = (chan_act && !SIM) ? addr_calc : 16'h0000;
    cal_channel   = chan_act ? ch : '0;
    quad_addr     = chan_act ? 9'(ch >> 2) : 9'd0;
    case (state)
      IDLE: begin
        if (start || pending || auto_run) begin
          state_n = FIRST_ST;
          launch  = 1'b1;
        end
      end
      RD_REQ:  state_n = RD_WAIT;
      RD_WAIT: begin
        if (!dprio_busy)       state_n = SAMPLE;
        else if (wait_timeout) state_n = NEXT;
      end
      SAMPLE: begin
        if (sample_end) begin
          if (SIM) state_n = last_ch ? DONE : NEXT;
          else     state_n = WR_REQ;
        end
      end
      WR_REQ:  state_n = WR_WAIT;
      WR_WAIT: begin
        if (!dprio_busy || wait_timeout) state_n = NEXT;
      end
      NEXT:    state_n = last_ch ? DONE : FIRST_ST;
      DONE: begin
        if (pending) begin
          state_n = FIRST_ST;
          launch  = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alt_cal_mc_sv.sv
// Testbench for alt_cal_mc_sv: a DPRIO-mode instance and a timer-model instance.
module tb_alt_cal_mc_sv;

  logic        clock = 1'b0;
  logic        reset, start, sim_start;
  logic [15:0] dprio_datain;
  logic        dprio_busy;
  logic [11:0] remap_addr;
  logic [7:0]  testbuses;

  logic        busy, done, error, dprio_rden, dprio_wren;
  logic [1:0]  cal_channel;
  logic [15:0] dprio_addr, dprio_dataout;
  logic [8:0]  quad_addr;

  logic        s_busy, s_done, s_error, s_rden, s_wren;
  logic [1:0]  s_cal_channel;
  logic [15:0] s_addr, s_dataout;
  logic [8:0]  s_quad;

  always #5 clock = ~clock;

  alt_cal_mc_sv #(.TIMEOUT_CYCLES(16'd16)) dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done), .error(error),
    .cal_channel(cal_channel), .dprio_addr(dprio_addr), .dprio_rden(dprio_rden),
    .dprio_wren(dprio_wren), .dprio_dataout(dprio_dataout), .dprio_datain(dprio_datain),
    .dprio_busy(dprio_busy), .quad_addr(quad_addr), .remap_addr(remap_addr), .testbuses(testbuses));

  alt_cal_mc_sv #(.SIM_MODEL_MODE("TRUE"), .SAMPLE_LENGTH(8'd10)) dut_sim (
    .clock(clock), .reset(reset), .start(sim_start), .busy(s_busy), .done(s_done), .error(s_error),
    .cal_channel(s_cal_channel), .dprio_addr(s_addr), .dprio_rden(s_rden),
    .dprio_wren(s_wren), .dprio_dataout(s_dataout), .dprio_datain(dprio_datain),
    .dprio_busy(dprio_busy), .quad_addr(s_quad), .remap_addr(remap_addr), .testbuses(testbuses));

  typedef struct {
    logic [15:0] din;
    int          k;      // comparator ones in the 100-cycle window
    int          b;      // dprio_busy cycles after each strobe
    logic [11:0] remap;
    logic [15:0] dout;
  } vec_t;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    logic [1:0]  ch;
  } wr_t;

  vec_t        vecs[6];
  wr_t         exp_wr[$];
  logic [15:0] exp_rd[$];

  int n_checks = 0, n_fail = 0;
  int done_cnt = 0, rd_cnt = 0, wr_cnt = 0;
  int s_busy_cyc = 0, s_done_cnt = 0, s_strobes = 0, s_max_ch = 0;
  int scnt = 1000, wcnt = 1000;
  logic [15:0] cur_din = 16'h0;
  int cur_k = 0, cur_b = 0;
  logic stuck = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic set_vec(input vec_t v);
    cur_din    = v.din;
    cur_k      = v.k;
    cur_b      = v.b;
    remap_addr = v.remap;
  endtask

  // Expected DPRIO traffic: reads for channels < n_rd, writes for channels < n_wr except skip.
  task automatic push_run(input vec_t v, input int n_rd, input int n_wr, input int skip);
    logic [15:0] a;
    wr_t w;
    for (int c = 0; c < 4; c++) begin
      a = 16'(c) * 16'h0040 + {4'b0000, v.remap};
      if (c < n_rd) exp_rd.push_back(a);
      if (c < n_wr && c != skip) begin
        w.addr = a; w.data = v.dout; w.ch = 2'(c);
        exp_wr.push_back(w);
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while (done_cnt < target && t < 3000) begin
      tick();
      t++;
    end
    check("run_completes", done_cnt, target);
  endtask

  task automatic idle_checks(input string tag);
    repeat (3) tick();
    check({tag, "_busy_low"}, busy, 1'b0);
    check({tag, "_writes_all_seen"}, exp_wr.size(), 0);
    check({tag, "_reads_all_seen"}, exp_rd.size(), 0);
    check({tag, "_idle_addr"}, dprio_addr, 16'h0);
  endtask

  // Monitor on the falling edge, then drive DPRIO/testbus responses for the next cycle.
  initial begin
    wr_t w;
    int s0;
    forever begin
      @(negedge clock);
      if (done) done_cnt++;
      if (dprio_rden) begin
        rd_cnt++;
        if (exp_rd.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_read: addr %0h, no read expected", dprio_addr);
        end else check("read_addr", dprio_addr, exp_rd.pop_front());
      end
      if (dprio_wren) begin
        wr_cnt++;
        if (exp_wr.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_write: addr %0h data %0h ch %0d, no write expected",
                   dprio_addr, dprio_dataout, cal_channel);
        end else begin
          w = exp_wr.pop_front();
          check("write_addr", dprio_addr, w.addr);
          check("write_data", dprio_dataout, w.data);
          check("write_channel", cal_channel, w.ch);
          check("write_quad", quad_addr, 9'd0);
        end
      end
      if (s_busy) s_busy_cyc++;
      if (s_done) s_done_cnt++;
      if (s_rden || s_wren || s_addr != 0 || s_dataout != 0) s_strobes++;
      if (int'(s_cal_channel) > s_max_ch) s_max_ch = int'(s_cal_channel);

      if (dprio_rden) scnt = 0; else if (scnt < 100000) scnt++;
      if (dprio_wren) wcnt = 0; else if (wcnt < 100000) wcnt++;
      s0 = ((cur_b > 1) ? cur_b : 1) + 1;
      dprio_busy   = stuck || (scnt < cur_b) || (wcnt < cur_b);
      dprio_datain = dprio_busy ? 16'hDEAD : cur_din;
      testbuses    = {7'h55, (scnt >= s0 && scnt < s0 + cur_k)};
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, still running");
    $fatal(1);
  end

  initial begin
    vec_t p;
    int tgt, t;
    vecs[0] = '{16'hA5A7, 100, 0, 12'h000, 16'hA5A8};
    vecs[1] = '{16'h000F, 100, 3, 12'h000, 16'h000F};
    vecs[2] = '{16'h0000,   0, 0, 12'h000, 16'h0000};
    vecs[3] = '{16'h1235,  50, 1, 12'h000, 16'h1234};
    vecs[4] = '{16'h1235,  51, 2, 12'h000, 16'h1236};
    vecs[5] = '{16'hFFF0,   0, 0, 12'h100, 16'hFFF0};
    p       = '{16'h3338, 100, 0, 12'h000, 16'h3339};

    reset = 1'b1; start = 1'b0; sim_start = 1'b0;
    remap_addr = 12'h0; dprio_datain = 16'h0; dprio_busy = 1'b0; testbuses = 8'h0;
    set_vec(vecs[0]);
    repeat (4) tick();
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_error", error, 1'b0);
    check("reset_strobes", {dprio_rden, dprio_wren}, 2'b00);
    check("reset_addr", dprio_addr, 16'h0);
    check("reset_dataout", dprio_dataout, 16'h0);
    check("reset_channel", {cal_channel, quad_addr}, 11'h0);
    check("reset_sim_busy", s_busy, 1'b0);

    // Power-up run launched by reset release.
    push_run(vecs[0], 4, 4, -1);
    reset = 1'b0;
    wait_done(1);
    idle_checks("powerup");
    check("powerup_done_once", done_cnt, 1);
    check("powerup_reads", rd_cnt, 4);
    check("powerup_writes", wr_cnt, 4);
    check("sim_busy_length", s_busy_cyc, 44);
    check("sim_done_once", s_done_cnt, 1);
    check("sim_channel_steps", s_max_ch, 3);

    for (int i = 1; i < 6; i++) begin
      set_vec(vecs[i]);
      push_run(vecs[i], 4, 4, -1);
      tgt = done_cnt + 1;
      pulse_start();
      wait_done(tgt);
      idle_checks("vector");
      check("vector_single_done", done_cnt, tgt);
      check("error_stays_low", error, 1'b0);
    end

    // Two start pulses during a run yield exactly one back-to-back extra run.
    set_vec(p);
    push_run(p, 4, 4, -1);
    push_run(p, 4, 4, -1);
    tgt = done_cnt + 1;
    pulse_start();
    repeat (60) tick();
    pulse_start();
    repeat (150) tick();
    pulse_start();
    wait_done(tgt);
    tick();
    check("pending_busy_held", busy, 1'b1);
    check("pending_immediate_read", dprio_rden, 1'b1);
    wait_done(tgt + 1);
    repeat (10) tick();
    check("pending_one_extra_only", done_cnt, tgt + 1);
    idle_checks("pending");

    // Reset during channel 2 sampling aborts with no further strobes.
    push_run(p, 3, 2, -1);
    tgt = done_cnt + 1;
    pulse_start();
    t = 0;
    while (!(dprio_rden && cal_channel == 2'd2) && t < 3000) begin tick(); t++; end
    check("reached_ch2_read", {dprio_rden, cal_channel}, 3'b110);
    repeat (10) tick();
    reset = 1'b1;
    tick();
    check("abort_busy", busy, 1'b0);
    check("abort_strobes", {dprio_rden, dprio_wren, done}, 3'b000);
    check("abort_channel", cal_channel, 2'd0);
    repeat (5) tick();
    check("abort_no_ch2_write", exp_wr.size(), 0);
    push_run(p, 4, 4, -1);
    reset = 1'b0;
    wait_done(tgt);
    idle_checks("rerun");

`ifdef ALT_CAL_SV_TIMEOUT_EN
    // Stuck dprio_busy on channel 1 read trips the watchdog and skips that write.
    set_vec(vecs[0]);
    push_run(vecs[0], 4, 4, 1);
    tgt = done_cnt + 1;
    pulse_start();
    t = 0;
    while (!(dprio_rden && cal_channel == 2'd1) && t < 3000) begin tick(); t++; end
    stuck = 1'b1;
    t = 0;
    while (!error && t < 100) begin tick(); t++; end
    stuck = 1'b0;
    check("watchdog_latency", t, 17);
    wait_done(tgt);
    idle_checks("watchdog");
    check("error_sticky", error, 1'b1);
    push_run(vecs[0], 4, 4, -1);
    pulse_start();
    tick();
    check("error_cleared_on_start", error, 1'b0);
    wait_done(tgt + 1);
    idle_checks("after_watchdog");
`endif

    // Timer model on its own start pulse.
    s_busy_cyc = 0;
    sim_start = 1'b1;
    tick();
    sim_start = 1'b0;
    repeat (80) tick();
    check("sim_busy_length_rerun", s_busy_cyc, 44);
    check("sim_no_dprio_traffic", s_strobes, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
